// File: rtl/regwb_arbiter.sv
// regwb_arbiter: two-requester register-bank writeback arbiter with alternating priority.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   hold                     stall; blocks all grants while 1
//   a_valid/a_addr/a_data    ALU writeback request, a_ready = accepted this cycle
//   b_valid/b_addr/b_data    load-unit writeback request, b_ready = accepted this cycle
//   RegEn/aw/dataIn_b        registered register-bank write port
//   wr_count                 saturating count of committed writes
//   conflict                 registered pulse after a both-valid, unheld cycle
module regwb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             a_valid,
    input  logic [4:0]       a_addr,
    input  logic [31:0]      a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [4:0]       b_addr,
    input  logic [31:0]      b_data,
    output logic             b_ready,
    output logic             RegEn,
    output logic [4:0]       aw,
    output logic [31:0]      dataIn_b,
    output logic [CNT_W-1:0] wr_count,
    output logic             conflict
);
    logic        prio;
    logic        both;
    logic        xfer;
    logic        commit;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    // Readiness is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        both     = rst_n & ~hold & a_valid & b_valid;
        a_ready  = rst_n & ~hold & a_valid & (~b_valid | ~prio);
        b_ready  = rst_n & ~hold & b_valid & (~a_valid | prio);
        xfer     = a_ready | b_ready;
        sel_addr = b_ready ? b_addr : a_addr;
        sel_data = b_ready ? b_data : a_data;
        // Writes to register 0 are accepted but never committed.
        commit   = xfer & (sel_addr != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            RegEn    <= 1'b0;
            aw       <= '0;
            dataIn_b <= '0;
            wr_count <= '0;
            conflict <= 1'b0;
        end else begin
            RegEn    <= commit;
            conflict <= both;
            if (both)
                prio <= ~prio;
            if (xfer) begin
                aw       <= sel_addr;
                dataIn_b <= sel_data;
            end
            if (commit && wr_count != '1)
                wr_count <= wr_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: table-driven directed bench for regwb_arbiter.
module tb_regwb_arbiter;
    typedef struct {
        logic        rst_n;
        logic        hold;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ar;
        logic        br;
        logic        re;
        logic [4:0]  aw;
        logic [31:0] d;
        logic [15:0] cnt;
        logic        conf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, hold, a_valid, b_valid;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, RegEn, conflict;
    logic [4:0]  aw;
    logic [31:0] dataIn_b;
    logic [15:0] wr_count;
    logic        a_ready2, b_ready2, RegEn2, conflict2;
    logic [4:0]  aw2;
    logic [31:0] dataIn_b2;
    logic [1:0]  wr_count2;
    int          nvec = 0;
    int          nmis = 0;
    vec_t        tbl[20];
    vec_t        v;

    always #5 clk = ~clk;

    regwb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .RegEn(RegEn), .aw(aw), .dataIn_b(dataIn_b), .wr_count(wr_count), .conflict(conflict)
    );

    regwb_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready2),
        .RegEn(RegEn2), .aw(aw2), .dataIn_b(dataIn_b2), .wr_count(wr_count2), .conflict(conflict2)
    );

    task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s vec %0d: got %h expected %h", n, i, act, exp);
        end
    endtask

    // Drive one cycle: readies are checked before the edge, registered outputs after it.
    task automatic apply(input vec_t x, input int i);
        rst_n = x.rst_n; hold = x.hold;
        a_valid = x.av; a_addr = x.aa; a_data = x.ad;
        b_valid = x.bv; b_addr = x.ba; b_data = x.bd;
        #1;
        chk("a_ready", i, 32'(a_ready), 32'(x.ar));
        chk("b_ready", i, 32'(b_ready), 32'(x.br));
        @(posedge clk);
        #1;
        chk("RegEn", i, 32'(RegEn), 32'(x.re));
        chk("aw", i, 32'(aw), 32'(x.aw));
        chk("dataIn_b", i, dataIn_b, x.d);
        chk("wr_count", i, 32'(wr_count), 32'(x.cnt));
        chk("conflict", i, 32'(conflict), 32'(x.conf));
    endtask

    initial begin
        //           rst hold av aa  ad            bv ba  bd         ar br re aw  d             cnt conf
        tbl[0]  = '{0, 0, 1, 5, 32'h1,        0, 0, 0,      0, 0, 0, 0, 32'h0,        0, 0};
        tbl[1]  = '{1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 0, 1, 5, 32'hDEADBEEF, 1, 0};
        tbl[2]  = '{1, 0, 0, 0, 32'h0,        0, 0, 0,      0, 0, 0, 5, 32'hDEADBEEF, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 32'h0,        1, 0, 32'h11, 0, 1, 0, 0, 32'h11,       1, 0};
        tbl[4]  = '{1, 0, 0, 0, 32'h0,        1, 7, 32'h22, 0, 1, 1, 7, 32'h22,       2, 0};
        tbl[5]  = '{0, 0, 1, 1, 32'hA1,       1, 2, 32'hB1, 0, 0, 0, 0, 32'h0,        0, 0};
        tbl[6]  = '{1, 0, 1, 1, 32'hA1,       1, 2, 32'hB1, 1, 0, 1, 1, 32'hA1,       1, 1};
        tbl[7]  = '{1, 0, 1, 1, 32'hA2,       1, 2, 32'hB1, 0, 1, 1, 2, 32'hB1,       2, 1};
        tbl[8]  = '{1, 0, 1, 1, 32'hA2,       1, 2, 32'hB2, 1, 0, 1, 1, 32'hA2,       3, 1};
        tbl[9]  = '{1, 0, 1, 1, 32'hA3,       1, 2, 32'hB2, 0, 1, 1, 2, 32'hB2,       4, 1};
        tbl[10] = '{1, 1, 1, 1, 32'hA3,       1, 2, 32'hB3, 0, 0, 0, 2, 32'hB2,       4, 0};
        tbl[11] = '{1, 1, 1, 1, 32'hA3,       1, 2, 32'hB3, 0, 0, 0, 2, 32'hB2,       4, 0};
        tbl[12] = '{1, 1, 1, 1, 32'hA3,       1, 2, 32'hB3, 0, 0, 0, 2, 32'hB2,       4, 0};
        tbl[13] = '{1, 0, 1, 1, 32'hA3,       1, 2, 32'hB3, 1, 0, 1, 1, 32'hA3,       5, 1};
        tbl[14] = '{1, 0, 1, 9, 32'hC1,       1, 9, 32'hC2, 0, 1, 1, 9, 32'hC2,       6, 1};
        tbl[15] = '{1, 0, 1, 9, 32'hC1,       0, 0, 0,      1, 0, 1, 9, 32'hC1,       7, 0};
        tbl[16] = '{1, 0, 1, 1, 32'hD1,       1, 2, 32'hD2, 1, 0, 1, 1, 32'hD1,       8, 1};
        tbl[17] = '{0, 0, 1, 1, 32'hD3,       1, 2, 32'hD2, 0, 0, 0, 0, 32'h0,        0, 0};
        tbl[18] = '{1, 0, 1, 1, 32'hD3,       1, 2, 32'hD2, 1, 0, 1, 1, 32'hD3,       1, 1};
        tbl[19] = '{1, 0, 0, 0, 32'h0,        0, 0, 0,      0, 0, 0, 1, 32'hD3,       1, 0};
        for (int i = 0; i < 20; i++)
            apply(tbl[i], i);

        // Saturation: the 2-bit counter must stick at 3 after reaching it.
        v = '{0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
        apply(v, 20);
        chk("wr_count2", 20, 32'(wr_count2), 32'd0);
        for (int k = 0; k < 5; k++) begin
            v = '{1, 0, 1, 5'(k + 3), 32'(k + 100), 0, 0, 0,
                  1, 0, 1, 5'(k + 3), 32'(k + 100), 16'(k + 1), 0};
            apply(v, 21 + k);
            chk("wr_count2", 21 + k, 32'(wr_count2), (k < 2) ? 32'(k + 1) : 32'd3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
